// File: rtl/iter_compare_unit.sv
// iter_compare_unit: compare/count unit that sits beside the ALU.
// Single-cycle ops (SLT/SLTU/MOVZ/MOVN/branch tests) finish in one cycle;
// CLO/CLZ scan CHUNK bits per cycle from the MSB.
// Optional feature macro: CMP_EARLY_EXIT_EN (stop scanning at the first chunk
// that ends the leading run). Default build scans a fixed NSCAN chunks.
module iter_compare_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cond_o
);

    localparam int unsigned NSCAN = WIDTH / CHUNK;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned IDX_W = (NSCAN > 1) ? $clog2(NSCAN) : 1;
    localparam int unsigned LZC_W = $clog2(CHUNK + 1);

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [3:0] OP_SLT  = 4'd0;
    localparam logic [3:0] OP_SLTU = 4'd1;
    localparam logic [3:0] OP_CLO  = 4'd2;
    localparam logic [3:0] OP_CLZ  = 4'd3;
    localparam logic [3:0] OP_MOVZ = 4'd4;
    localparam logic [3:0] OP_MOVN = 4'd5;
    localparam logic [3:0] OP_EQ   = 4'd6;
    localparam logic [3:0] OP_NE   = 4'd7;
    localparam logic [3:0] OP_GEZ  = 4'd8;
    localparam logic [3:0] OP_GTZ  = 4'd9;
    localparam logic [3:0] OP_LTZ  = 4'd10;
    localparam logic [3:0] OP_LEZ  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               cond_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   idx_q;
    logic               found_q;

    logic [WIDTH-1:0]   sc_result_c;
    logic               sc_cond_c;
    logic               a_neg_c;
    logic               a_zero_c;
    logic [CHUNK-1:0]   chunk_c;
    logic [LZC_W-1:0]   chunk_lz_c;
    logic [CNT_W-1:0]   count_next_c;
    logic               scan_stop_c;

    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign cond_o   = cond_q;

    // Single-cycle op results computed straight from the live operands.
    always_comb begin
        sc_result_c = '0;
        sc_cond_c   = 1'b0;
        a_neg_c     = a_i[WIDTH-1];
        a_zero_c    = (a_i == '0);
        case (op_i)
            OP_SLT:  sc_cond_c = ($signed(a_i) < $signed(b_i));
            OP_SLTU: sc_cond_c = (a_i < b_i);
            OP_MOVZ: sc_cond_c = (b_i == '0);
            OP_MOVN: sc_cond_c = (b_i != '0);
            OP_EQ:   sc_cond_c = (a_i == b_i);
            OP_NE:   sc_cond_c = (a_i != b_i);
            OP_GEZ:  sc_cond_c = !a_neg_c;
            OP_GTZ:  sc_cond_c = !a_neg_c && !a_zero_c;
            OP_LTZ:  sc_cond_c = a_neg_c;
            OP_LEZ:  sc_cond_c = a_neg_c || a_zero_c;
            default: sc_cond_c = 1'b0;
        endcase
        case (op_i)
            OP_SLT, OP_SLTU, OP_EQ, OP_NE,
            OP_GEZ, OP_GTZ, OP_LTZ, OP_LEZ: sc_result_c = WIDTH'(sc_cond_c);
            OP_MOVZ, OP_MOVN:               sc_result_c = a_i;
            default:                        sc_result_c = '0;
        endcase
    end

    // Leading-zero run of the current top chunk and the updated count.
    always_comb begin
        chunk_c    = data_q[WIDTH-1 -: CHUNK];
        chunk_lz_c = LZC_W'(CHUNK);
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (chunk_c[i]) begin
                chunk_lz_c = LZC_W'(int'(CHUNK) - 1 - i);
            end
        end
        count_next_c = found_q ? count_q : (count_q + CNT_W'(chunk_lz_c));
        scan_stop_c  = (idx_q == IDX_W'(NSCAN - 1)) ||
                       (EARLY_EXIT && (chunk_c != '0));
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cond_q   <= 1'b0;
            data_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && ready_q) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (op_i == OP_CLO || op_i == OP_CLZ) begin
                            data_q  <= (op_i == OP_CLO) ? ~a_i : a_i;
                            count_q <= '0;
                            idx_q   <= '0;
                            found_q <= 1'b0;
                            state_q <= ST_SCAN;
                        end else begin
                            result_q <= sc_result_c;
                            cond_q   <= sc_cond_c;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_SCAN: begin
                    count_q <= count_next_c;
                    found_q <= found_q || (chunk_c != '0);
                    data_q  <= data_q << CHUNK;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (scan_stop_c) begin
                        result_q <= WIDTH'(count_next_c);
                        cond_q   <= (count_next_c == CNT_W'(WIDTH));
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_compare_unit.sv
// Bench for iter_compare_unit: cycle-level behavioural model plus one
// per-cycle compare process; directed spec cases, reset abort, random traffic.
module tb_iter_compare_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [3:0]    op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          ready_o;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  result_o;
    logic          cond_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: an op occupies intervals acc..fin; done in interval fin.
    bit           have_op = 1'b0;
    int           acc = 0;
    int           fin = 0;
    logic [W-1:0] cur_res = '0;
    logic         cur_cond = 1'b0;
    logic [W-1:0] prev_res = '0;
    logic         prev_cond = 1'b0;

    iter_compare_unit #(.WIDTH(32), .CHUNK(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .cond_o   (cond_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: result, cond and latency straight from the op definitions.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic c, output int lat);
        logic [W-1:0] v;
        int n;
        r = '0; c = 1'b0; lat = 1;
        case (op)
            4'd0: begin c = (int'(a) < int'(b)); r = {31'b0, c}; end
            4'd1: begin c = (a < b); r = {31'b0, c}; end
            4'd2, 4'd3: begin
                v = (op == 4'd2) ? ~a : a;
                n = 0;
                while (n < W && v[W-1-n] == 1'b0) n++;
                r = n;
                c = (n == W);
`ifdef CMP_EARLY_EXIT_EN
                lat = ((n / 4 < 7) ? n / 4 : 7) + 2;
`else
                lat = 9;
`endif
            end
            4'd4: begin r = a; c = (b == 0); end
            4'd5: begin r = a; c = (b != 0); end
            4'd6: begin c = (a == b); r = {31'b0, c}; end
            4'd7: begin c = (a != b); r = {31'b0, c}; end
            4'd8: begin c = (int'(a) >= 0); r = {31'b0, c}; end
            4'd9: begin c = (int'(a) > 0); r = {31'b0, c}; end
            4'd10: begin c = (int'(a) < 0); r = {31'b0, c}; end
            4'd11: begin c = (int'(a) <= 0); r = {31'b0, c}; end
            default: begin r = '0; c = 1'b0; end
        endcase
    endfunction

    function automatic bit model_idle();
        return !have_op || (cyc > fin);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive inputs for the next edge; the model accepts if it is idle.
    task automatic drive(input logic s, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int lat;
        start_i = s; op_i = op; a_i = a; b_i = b;
        if (s && rst_n && model_idle()) begin
            prev_res  = cur_res;
            prev_cond = cur_cond;
            model(op, a, b, cur_res, cur_cond, lat);
            acc = cyc + 1;
            fin = cyc + lat;
            have_op = 1'b1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && !model_idle(); i++) step();
    endtask

    task automatic run_dir(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] er, input logic ec);
        wait_idle();
        drive(1'b1, op, a, b);
        step();
        drive(1'b0, 4'd0, '0, '0);
        wait_idle();
        chk({nm, "_res"}, result_o, er);
        chk({nm, "_cond"}, {31'b0, cond_o}, {31'b0, ec});
    endtask

    task automatic model_reset();
        have_op = 1'b0;
        cur_res = '0; cur_cond = 1'b0;
        prev_res = '0; prev_cond = 1'b0;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        bit e_busy, e_done, e_new;
        e_busy = have_op && cyc >= acc && cyc <= fin;
        e_done = have_op && cyc == fin;
        e_new  = have_op && cyc >= fin;
        chk("ready", {31'b0, ready_o}, {31'b0, !e_busy});
        chk("busy", {31'b0, busy_o}, {31'b0, e_busy});
        chk("done", {31'b0, done_o}, {31'b0, e_done});
        chk("result", result_o, e_new ? cur_res : prev_res);
        chk("cond", {31'b0, cond_o}, {31'b0, e_new ? cur_cond : prev_cond});
    end

    function automatic logic [W-1:0] gen_a();
        logic [W-1:0] v;
        int k;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: begin
                k = $urandom_range(0, 31);
                v = ($urandom & (32'hFFFFFFFF >> k)) | (32'h80000000 >> k);
                if ($urandom_range(0, 1) == 1) v = ~v;
            end
            2: v = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h0;
            default: v = ($urandom_range(0, 1) == 1) ? 32'h80000000 : W'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] r;
        logic c;
        int lat;

        rst_n = 1'b0;
        start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Pin the model with hand-computed values.
        model(4'd3, 32'h00000F00, 0, r, c, lat);
        chk("pin_clz_f00", r, 32'd20);
`ifdef CMP_EARLY_EXIT_EN
        chk("pin_clz_f00_lat", lat, 7);
`else
        chk("pin_clz_f00_lat", lat, 9);
`endif
        model(4'd2, 32'hFFFFFFFF, 0, r, c, lat);
        chk("pin_clo_ones", r, 32'd32);
        chk("pin_clo_ones_lat", lat, 9);
        model(4'd0, 32'hFFFFFFFF, 1, r, c, lat);
        chk("pin_slt", r, 32'd1);
        chk("pin_slt_lat", lat, 1);

        // Directed cases.
        run_dir("slt", 4'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1);
        run_dir("sltu", 4'd1, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        run_dir("clz_f00", 4'd3, 32'h00000F00, 32'd0, 32'd20, 1'b0);
        run_dir("clz_zero", 4'd3, 32'h0, 32'd0, 32'd32, 1'b1);
        run_dir("clo_ones", 4'd2, 32'hFFFFFFFF, 32'd0, 32'd32, 1'b1);
        run_dir("clo_3", 4'd2, 32'hE0000000, 32'd0, 32'd3, 1'b0);
        run_dir("movz", 4'd4, 32'h1234, 32'd0, 32'h1234, 1'b1);
        run_dir("movn", 4'd5, 32'h55AA, 32'd0, 32'h55AA, 1'b0);
        run_dir("lez", 4'd11, 32'h0, 32'd0, 32'd1, 1'b1);
        run_dir("gtz", 4'd9, 32'h80000000, 32'd0, 32'd0, 1'b0);
        run_dir("eq", 4'd6, 32'h77, 32'h77, 32'd1, 1'b1);
        run_dir("illegal", 4'd13, 32'hFFFFFFFF, 32'h5, 32'd0, 1'b0);

        // CLO in flight: ignored SLT at SCAN cycle 3, reset at SCAN cycle 5.
        wait_idle();
        drive(1'b1, 4'd2, 32'hFFFFFFFF, 32'd0);
        step(); drive(1'b0, 4'd0, '0, '0);
        step();
        step(); drive(1'b1, 4'd0, 32'hFFFFFFFF, 32'd1);
        step(); drive(1'b0, 4'd0, '0, '0);
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_cond", {31'b0, cond_o}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        run_dir("post_rst_slt", 4'd0, 32'h5, 32'h9, 32'd1, 1'b1);

        // Back-to-back issue with start held high.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'(i % 2 == 0 ? 7 : 1), $urandom, $urandom);
            step();
        end
        drive(1'b0, 4'd0, '0, '0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), gen_a(),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            step();
        end
        drive(1'b0, 4'd0, '0, '0);
        wait_idle();
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
